// File: rtl/conv_pkg.sv
// Shared constants and FSM encoding for the 3x3 convolver sequencer.
package conv_pkg;
   localparam int BIT_LEN = 8;
   localparam int M_LEN   = 3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_KLOAD,
      S_ROW,
      S_STREAM,
      S_FLUSH,
      S_DONE
   } state_t;
endpackage

// File: rtl/conv_addr_gen.sv
// Row-base accumulator plus column offset; yields the three vertically adjacent read addresses.
// In kernel mode the base is the kernel address and the row stride is M_LEN.
module conv_addr_gen
   import conv_pkg::*;
#(
   parameter int ADDR_LEN = 16,
   parameter int DIM_LEN  = 10
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic [ADDR_LEN-1:0] load_base,
   input  logic                adv,
   input  logic [DIM_LEN-1:0]  width,
   input  logic                kmode,
   input  logic [ADDR_LEN-1:0] k_base,
   input  logic [DIM_LEN-1:0]  col,
   output logic [ADDR_LEN-1:0] addr0,
   output logic [ADDR_LEN-1:0] addr1,
   output logic [ADDR_LEN-1:0] addr2
);
   logic [ADDR_LEN-1:0] row_base;
   logic [ADDR_LEN-1:0] base;
   logic [ADDR_LEN-1:0] stride;

   always_ff @(posedge clk) begin
      if (rst)       row_base <= '0;
      else if (load) row_base <= load_base;
      else if (adv)  row_base <= row_base + ADDR_LEN'(width);
   end

   always_comb begin
      base   = kmode ? k_base : row_base;
      stride = kmode ? ADDR_LEN'(M_LEN) : ADDR_LEN'(width);
      addr0  = base + ADDR_LEN'(col);
      addr1  = addr0 + stride;
      addr2  = addr1 + stride;
   end
endmodule

// File: rtl/conv_seq_ctrl.sv
// Sequencer for the 3x3 convolver: kernel load, banded image sweep, result write strobes.
// Optional CONV_SEQ_CTRL_PERF_EN adds saturating stall/job cycle counters.
module conv_seq_ctrl
   import conv_pkg::*;
#(
   parameter int ADDR_LEN = 16,
   parameter int DIM_LEN  = 10,
   parameter int RD_LAT   = 1
)(
   input  logic                CLK100MHZ,
   input  logic                i_reset,
   input  logic                i_start,
   input  logic [DIM_LEN-1:0]  i_width,
   input  logic [DIM_LEN-1:0]  i_height,
   input  logic [ADDR_LEN-1:0] i_img_base,
   input  logic [ADDR_LEN-1:0] i_k_base,
   input  logic [ADDR_LEN-1:0] i_out_base,
   input  logic                i_stall,
   output logic                o_rd_en,
   output logic [ADDR_LEN-1:0] o_rd_addr0,
   output logic [ADDR_LEN-1:0] o_rd_addr1,
   output logic [ADDR_LEN-1:0] o_rd_addr2,
   output logic                o_conv_valid,
   output logic                o_conv_selK_I,
   output logic                o_wr_en,
   output logic [ADDR_LEN-1:0] o_wr_addr,
   output logic                o_busy,
   output logic                o_done,
   output logic                o_err
`ifdef CONV_SEQ_CTRL_PERF_EN
   ,
   output logic [31:0]         o_stall_cycles,
   output logic [31:0]         o_job_cycles
`endif
);
   state_t               state_q, state_d;
   logic [DIM_LEN-1:0]   c_q, c_d, r_q, r_d;
   logic [DIM_LEN-1:0]   width_q, height_q;
   logic [ADDR_LEN-1:0]  k_base_q, wr_addr_q;
   logic                 err_q, wr_en_q;
   logic                 issue, issue_img, kmode, row_adv;
   logic                 start_acc, dims_ok;
   logic [ADDR_LEN-1:0]  a0, a1, a2;
   logic [RD_LAT:1]      vld_pipe, sel_pipe, wc_pipe;

   assign dims_ok   = (i_width >= DIM_LEN'(M_LEN)) && (i_height >= DIM_LEN'(M_LEN));
   assign start_acc = (state_q == S_IDLE) && i_start && dims_ok;

   always_comb begin
      state_d   = state_q;
      c_d       = c_q;
      r_d       = r_q;
      issue     = 1'b0;
      issue_img = 1'b0;
      kmode     = 1'b0;
      row_adv   = 1'b0;
      case (state_q)
         S_IDLE: if (start_acc) begin
            state_d = S_KLOAD;
            c_d     = '0;
            r_d     = '0;
         end
         S_KLOAD: begin
            kmode = 1'b1;
            if (!i_stall) begin
               issue = 1'b1;
               if (c_q == DIM_LEN'(M_LEN - 1)) begin
                  state_d = S_ROW;
                  c_d     = '0;
               end else c_d = c_q + 1'b1;
            end
         end
         S_ROW: begin
            c_d     = '0;
            state_d = S_STREAM;
         end
         S_STREAM: if (!i_stall) begin
            issue     = 1'b1;
            issue_img = 1'b1;
            if (c_q == width_q - 1'b1) begin
               c_d = '0;
               if (r_q == height_q - DIM_LEN'(M_LEN)) state_d = S_FLUSH;
               else begin
                  r_d     = r_q + 1'b1;
                  row_adv = 1'b1;
                  state_d = S_ROW;
               end
            end else c_d = c_q + 1'b1;
         end
         S_FLUSH: if (vld_pipe == '0) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK100MHZ) begin
      if (i_reset) begin
         state_q   <= S_IDLE;
         c_q       <= '0;
         r_q       <= '0;
         width_q   <= '0;
         height_q  <= '0;
         k_base_q  <= '0;
         wr_addr_q <= '0;
         err_q     <= 1'b0;
         wr_en_q   <= 1'b0;
         vld_pipe  <= '0;
         sel_pipe  <= '0;
         wc_pipe   <= '0;
      end else begin
         state_q <= state_d;
         c_q     <= c_d;
         r_q     <= r_d;
         err_q   <= (state_q == S_IDLE) && i_start && !dims_ok;
         if (start_acc) begin
            width_q   <= i_width;
            height_q  <= i_height;
            k_base_q  <= i_k_base;
            wr_addr_q <= i_out_base;
         end else if (wr_en_q) wr_addr_q <= wr_addr_q + 1'b1;
         // The first two columns of a row only prime the convolver window.
         vld_pipe[1] <= issue;
         sel_pipe[1] <= issue_img;
         wc_pipe[1]  <= issue_img && (c_q >= DIM_LEN'(M_LEN - 1));
         for (int k = 2; k <= RD_LAT; k++) begin
            vld_pipe[k] <= vld_pipe[k-1];
            sel_pipe[k] <= sel_pipe[k-1];
            wc_pipe[k]  <= wc_pipe[k-1];
         end
         wr_en_q <= wc_pipe[RD_LAT];
      end
   end

   conv_addr_gen #(.ADDR_LEN(ADDR_LEN), .DIM_LEN(DIM_LEN)) u_addr (
      .clk      (CLK100MHZ),
      .rst      (i_reset),
      .load     (start_acc),
      .load_base(i_img_base),
      .adv      (row_adv),
      .width    (width_q),
      .kmode    (kmode),
      .k_base   (k_base_q),
      .col      (c_q),
      .addr0    (a0),
      .addr1    (a1),
      .addr2    (a2)
   );

   assign o_rd_en       = issue;
   assign o_rd_addr0    = issue ? a0 : '0;
   assign o_rd_addr1    = issue ? a1 : '0;
   assign o_rd_addr2    = issue ? a2 : '0;
   assign o_conv_valid  = vld_pipe[RD_LAT];
   assign o_conv_selK_I = sel_pipe[RD_LAT];
   assign o_wr_en       = wr_en_q;
   assign o_wr_addr     = wr_addr_q;
   assign o_busy        = (state_q != S_IDLE) && (state_q != S_DONE);
   assign o_done        = (state_q == S_DONE);
   assign o_err         = err_q;

`ifdef CONV_SEQ_CTRL_PERF_EN
   logic [31:0] stall_q, job_q;

   always_ff @(posedge CLK100MHZ) begin
      if (i_reset) begin
         stall_q <= '0;
         job_q   <= '0;
      end else if (start_acc) begin
         stall_q <= '0;
         job_q   <= '0;
      end else begin
         if (o_busy && (job_q != '1)) job_q <= job_q + 1'b1;
         if (o_busy && i_stall && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      end
   end

   assign o_stall_cycles = stall_q;
   assign o_job_cycles   = job_q;
`endif
endmodule
